// File: rtl/pixel_writer_if.sv
// Pixel input and framebuffer write port bundle for pixel_writer.
// The slave side is the writer itself; the master side drives pixels and acks.
interface pixel_writer_if;
    logic [23:0] kbus;
    logic        pix_tgl;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_ack;
    logic        busy;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  clip_cnt;

    modport slave (
        input  kbus,
        input  pix_tgl,
        input  fb_ack,
        output fb_addr,
        output fb_data,
        output fb_we,
        output busy,
        output count,
        output overflow,
        output clip_cnt
    );

    modport master (
        output kbus,
        output pix_tgl,
        output fb_ack,
        input  fb_addr,
        input  fb_data,
        input  fb_we,
        input  busy,
        input  count,
        input  overflow,
        input  clip_cnt
    );
endinterface

// File: rtl/pixel_writer.sv
// Toggle-strobed pixel capture with clipping, a small FIFO and a held-request
// framebuffer write port. All outputs are registered.
module pixel_writer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XRES  = 160,
    parameter int unsigned YRES  = 120
) (
    input  logic           clk,
    input  logic           rst,
    pixel_writer_if.slave  bus
);
    localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  FullCnt = 5'(DEPTH);
    localparam logic [8:0]  XLim    = 9'(XRES);
    localparam logic [8:0]  YLim    = 9'(YRES);

    typedef enum logic {StIdle, StWrite} state_e;

    state_e            state_q, state_d;
    logic              tgl_q;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   rd_nxt;
    logic [4:0]        count_q, count_d;
    logic [15:0]       fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic              fb_we_q, fb_we_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        clip_cnt_q, clip_cnt_d;
    logic [23:0]       mem_q [DEPTH];
    logic [23:0]       mem_d [DEPTH];

    logic              new_pix;
    logic              clipped;
    logic              pop;
    logic              push;
    logic [23:0]       entry;
    logic              present;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_we_d    = fb_we_q;
        overflow_d = overflow_q;
        clip_cnt_d = clip_cnt_q;
        mem_d      = mem_q;
        entry      = mem_q[rd_ptr_q];
        present    = 1'b0;
        rd_nxt     = rd_ptr_q + PtrW'(1);

        new_pix = (bus.pix_tgl != tgl_q);
        clipped = ({1'b0, bus.kbus[23:16]} >= XLim) || ({1'b0, bus.kbus[15:8]} >= YLim);
        pop     = (state_q == StWrite) && bus.fb_ack;
        // A full FIFO still accepts when the head leaves at the same edge.
        push    = new_pix && !clipped && ((count_q != FullCnt) || pop);

        if (new_pix && clipped && (clip_cnt_q != 8'hFF)) begin
            clip_cnt_d = clip_cnt_q + 8'd1;
        end
        if (new_pix && !clipped && !push) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = bus.kbus;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_nxt;
        end
        count_d = count_q + {4'b0, push} - {4'b0, pop};

        unique case (state_q)
            StIdle: begin
                if (count_q != 5'd0) begin
                    state_d = StWrite;
                    fb_we_d = 1'b1;
                    present = 1'b1;
                end
            end
            StWrite: begin
                if (pop) begin
                    if (count_d != 5'd0) begin
                        // With only the head stored, the survivor is the pixel arriving now.
                        entry   = (count_q > 5'd1) ? mem_q[rd_nxt] : bus.kbus;
                        present = 1'b1;
                    end else begin
                        state_d = StIdle;
                        fb_we_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (present) begin
            fb_addr_d = {entry[15:8], entry[23:16]};
            fb_data_d = entry[7:0];
        end

        busy_d = (count_d != 5'd0) || fb_we_d;
    end

    always_ff @(posedge clk) begin
        tgl_q <= bus.pix_tgl;
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_we_q    <= fb_we_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.fb_we    = fb_we_q;
    assign bus.busy     = busy_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.clip_cnt = clip_cnt_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed scenarios plus randomized traffic for pixel_writer, checked every
// cycle against a queue-based model of the pixel pipeline.
module tb_pixel_writer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XRES  = 160;
    localparam int unsigned YRES  = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_writer_if pif ();

    pixel_writer #(
        .DEPTH (DEPTH),
        .XRES  (XRES),
        .YRES  (YRES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif.slave)
    );

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [23:0] m_q [$];
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic [7:0]  m_clip;
    logic        m_ovf;
    logic        m_tgl;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic        newpix;
        logic        pop;
        logic        do_push;
        int          prior;
        logic [23:0] e;
        if (rst) begin
            m_q.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_ovf  = 1'b0;
            m_clip = '0;
            m_tgl  = pif.pix_tgl;
            return;
        end
        newpix  = (pif.pix_tgl != m_tgl);
        m_tgl   = pif.pix_tgl;
        pop     = m_we && pif.fb_ack;
        prior   = m_q.size();
        do_push = 1'b0;
        if (newpix) begin
            if (int'(pif.kbus[23:16]) >= XRES || int'(pif.kbus[15:8]) >= YRES) begin
                if (m_clip != 8'd255) m_clip = m_clip + 8'd1;
            end else if (prior < DEPTH || pop) begin
                do_push = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pif.kbus);
        if (m_we) begin
            if (pop) begin
                if (m_q.size() > 0) begin
                    e = m_q[0];
                    m_addr = {e[15:8], e[23:16]};
                    m_data = e[7:0];
                end else begin
                    m_we = 1'b0;
                end
            end
        end else if (prior > 0) begin
            e = m_q[0];
            m_we   = 1'b1;
            m_addr = {e[15:8], e[23:16]};
            m_data = e[7:0];
        end
    endtask

    task automatic compare_all();
        check_eq("fb_we",    pif.fb_we,    m_we);
        check_eq("fb_addr",  pif.fb_addr,  m_addr);
        check_eq("fb_data",  pif.fb_data,  m_data);
        check_eq("busy",     pif.busy,     (m_q.size() > 0) || m_we);
        check_eq("count",    pif.count,    m_q.size());
        check_eq("overflow", pif.overflow, m_ovf);
        check_eq("clip_cnt", pif.clip_cnt, m_clip);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
        pif.kbus    = {x, y, c};
        pif.pix_tgl = ~pif.pix_tgl;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        pif.kbus    = '0;
        pif.pix_tgl = 1'b0;
        pif.fb_ack  = 1'b0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single pixel through an acking framebuffer.
        pif.fb_ack = 1'b1;
        send(8'h0A, 8'h14, 8'h3F);
        tick();
        check_eq("single_we",   pif.fb_we,   1'b1);
        check_eq("single_addr", pif.fb_addr, 16'h140A);
        check_eq("single_data", pif.fb_data, 8'h3F);
        tick();
        check_eq("single_done_we",   pif.fb_we, 1'b0);
        check_eq("single_done_busy", pif.busy,  1'b0);

        // Backpressure then drain in order.
        pif.fb_ack = 1'b0;
        send(8'd1, 8'd2, 8'h11);
        send(8'd3, 8'd4, 8'h22);
        send(8'd5, 8'd6, 8'h33);
        tick();
        check_eq("bp_count", pif.count, 5'd3);
        pif.fb_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Overflow: nine pixels into an eight-deep FIFO.
        pif.fb_ack = 1'b0;
        for (int i = 0; i < 9; i++) send(8'(i), 8'(i + 10), 8'(i + 100));
        check_eq("ovf_count", pif.count,    5'd8);
        check_eq("ovf_flag",  pif.overflow, 1'b1);
        pif.fb_ack = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_eq("ovf_sticky", pif.overflow, 1'b1);

        // Full FIFO with a pop and a push at the same edge.
        do_reset();
        pif.fb_ack = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i + 20), 8'(i + 30), 8'(i));
        tick();
        pif.fb_ack = 1'b1;
        send(8'd99, 8'd98, 8'hAB);
        check_eq("fullpop_count", pif.count,    5'd8);
        check_eq("fullpop_ovf",   pif.overflow, 1'b0);
        for (int i = 0; i < 12; i++) tick();

        // Clipping and saturation.
        do_reset();
        send(8'd160, 8'd5, 8'h01);
        send(8'd3, 8'd120, 8'h02);
        tick();
        tick();
        check_eq("clip_two", pif.clip_cnt, 8'd2);
        check_eq("clip_we",  pif.fb_we,    1'b0);
        for (int i = 0; i < 300; i++) send(8'(XRES + (i % 96)), 8'(i), 8'(i));
        check_eq("clip_sat", pif.clip_cnt, 8'd255);

        // Reset in the middle of a write burst.
        pif.fb_ack = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(i), 8'(i), 8'(i));
        tick();
        pif.fb_ack = 1'b1;
        do_reset();
        check_eq("rst_we",    pif.fb_we, 1'b0);
        check_eq("rst_count", pif.count, 5'd0);
        check_eq("rst_busy",  pif.busy,  1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("rst_static", pif.fb_we, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pif.fb_ack = ($urandom_range(0, 99) < 55);
            rst        = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) < 60) begin
                pif.kbus[23:16] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255))
                                                               : 8'($urandom_range(0, 159));
                pif.kbus[15:8]  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(120, 255))
                                                               : 8'($urandom_range(0, 119));
                pif.kbus[7:0]   = 8'($urandom);
                pif.pix_tgl     = ~pif.pix_tgl;
            end else begin
                pif.kbus = 24'($urandom);
            end
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter: DEPTH, 8, pixel FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter: XRES, 160, horizontal resolution; pixels with X >= XRES are clipped.
REQ-003 Parameter: YRES, 120, vertical resolution; pixels with Y >= YRES are clipped.
REQ-004 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: kbus  input  24  pixel word from the command/datapath stage: [23:16]=X, [15:8]=Y, [7:0]=colour.
REQ-007 Port: pix_tgl  input  1  pixel strobe; every level change (either direction) marks one new pixel on kbus.
REQ-008 Port: fb_addr  output  16  framebuffer address = {Y, X}.
REQ-009 Port: fb_data  output  8  framebuffer write colour.
REQ-010 Port: fb_we  output  1  write request; held until acknowledged.
REQ-011 Port: fb_ack  input  1  framebuffer accepts the write when high while fb_we is high.
REQ-012 Port: busy  output  1  high when FIFO non-empty or fb_we high.
REQ-013 Port: count  output  5  current FIFO occupancy, 0..DEPTH.
REQ-014 Port: overflow  output  1  sticky; set when a pixel is dropped because the FIFO is full.
REQ-015 Port: clip_cnt  output  8  saturating count of clipped pixels.

Function
REQ-016 Strobe detect: tgl_q registers pix_tgl each cycle; new pixel when pix_tgl != tgl_q at a rising edge; kbus is sampled at that same edge.
REQ-017 Clip: on a new pixel with X >= XRES or Y >= YRES, the pixel is not pushed and clip_cnt increments, saturating at 255.
REQ-018 Push: an in-range new pixel is written to the FIFO tail at the detecting edge if count < DEPTH, or if count == DEPTH and a pop occurs at the same edge.
REQ-019 Drop: an in-range pixel arriving when count == DEPTH with no same-edge pop is discarded, overflow is set to 1, and FIFO contents are unchanged.
REQ-020 FSM states: IDLE (fb_we=0) and WRITE (fb_we=1, fb_addr/fb_data = head entry, held stable).
REQ-021 IDLE -> WRITE at the first edge where count > 0; a pixel pushed into an empty FIFO at edge N gives fb_we=1 after edge N+1.
REQ-022 In WRITE with fb_ack=1 at an edge: the head is popped. If another entry remains, the state stays WRITE and fb_we stays high with the next entry presented after that edge. Otherwise the state returns to IDLE.
REQ-023 In WRITE with fb_ack=0: no change; fb_addr, fb_data and fb_we hold.
REQ-024 fb_ack while in IDLE is ignored.
REQ-025 Simultaneous push and pop at the same edge: count is unchanged and ordering is preserved (strict FIFO order).
REQ-026 FIFO read/write pointers wrap modulo DEPTH; count is tracked separately so that full and empty are distinct.
REQ-027 No combinational path from kbus or pix_tgl to any output.

Reset
REQ-028 While rst=1 at an edge: FSM enters IDLE; fb_we=0; fb_addr=0; fb_data=0; count=0; pointers=0; overflow=0; clip_cnt=0; busy=0.
REQ-029 During reset tgl_q loads pix_tgl, so no pixel is detected at the first edge after reset deasserts unless pix_tgl changes.
REQ-030 Reset mid-write: fb_we drops at the reset edge, pending entries are discarded, and an fb_ack arriving that cycle has no effect.

Verification
REQ-031 Single pixel: kbus=0x0A_14_3F with pix_tgl toggled at edge 1 and fb_ack=1 -> fb_we=1 after edge 2, with fb_addr=0x140A and fb_data=0x3F; after edge 3, fb_we=0 and busy=0.
REQ-032 Backpressure/ordering: push 3 pixels on consecutive edges with fb_ack=0, then hold fb_ack=1 -> count reaches 3; writes occur in push order on three consecutive edges with fb_we continuously high.
REQ-033 Overflow: DEPTH=8, fb_ack=0, 9 toggles -> count=8, overflow=1; the 9th pixel never appears; overflow stays 1 after the FIFO drains.
REQ-034 Full with simultaneous pop: FIFO full, fb_ack=1 and a new toggle at the same edge -> count stays 8 and overflow stays 0.
REQ-035 Clip: X=160,Y=5 then X=3,Y=120 -> no writes, clip_cnt=2; 300 clipped pixels -> clip_cnt=255.
REQ-036 Reset: assert rst with 4 entries pending and fb_we=1 -> after the edge fb_we=0, count=0, busy=0; a static pix_tgl after release produces no write.
